// File: rtl/seg_stream_decoder_if.sv
// Display-bus bundle between the 7-segment stream source and the decoder.
// The source (master) drives the segment byte and observes the decoded
// results; the decoder (slave) samples the byte and drives everything else.
// dbg_state mirrors the frame FSM state: 0=HUNT, 1=C1, 2=C2, 3=C3, 4=C4.
// The bus has no backpressure. char_valid, frame_valid and error are
// single-cycle pulses; the other outputs hold their last value.
interface seg_stream_decoder_if;
  logic [7:0]  seg_in;
  logic        char_valid;
  logic [3:0]  char_code;
  logic        frame_valid;
  logic        frame_is_over;
  logic [15:0] score_bcd;
  logic        error;
  logic [2:0]  dbg_state;

  modport master (
    output seg_in,
    input  char_valid, char_code, frame_valid, frame_is_over, score_bcd,
           error, dbg_state
  );

  modport slave (
    input  seg_in,
    output char_valid, char_code, frame_valid, frame_is_over, score_bcd,
           error, dbg_state
  );
endinterface

// File: rtl/seg_stream_decoder.sv
// Receive-side decoder for a 7-segment character stream (.GFEDCBA).
// Pipeline: input sample register -> run tracker / character accept ->
// frame FSM. Characters are accepted once a pattern has been stable for
// STABLE_CYCLES samples and again every SLOT_CYCLES samples after that.
// Accepted characters are assembled into blank-delimited 4-character
// frames that decode to a BCD score or to the word OVER.
module seg_stream_decoder #(
  parameter int STABLE_CYCLES = 8,
  parameter int SLOT_CYCLES   = 10000000,
  parameter int CNT_W         = 24
) (
  input  logic                clk,
  input  logic                rst,
  seg_stream_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    C3   = 3'd3,
    C4   = 3'd4
  } state_t;

  localparam logic [3:0] CODE_BLANK   = 4'hA;
  localparam logic [3:0] CODE_DASH    = 4'hE;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [3:0] decode_seg(input logic [7:0] pat);
    logic [3:0] code;
    case (pat)
      8'h3F:   code = 4'h0;
      8'h06:   code = 4'h1;
      8'h5B:   code = 4'h2;
      8'h4F:   code = 4'h3;
      8'h66:   code = 4'h4;
      8'h6D:   code = 4'h5;
      8'h7D:   code = 4'h6;
      8'h07:   code = 4'h7;
      8'h7F:   code = 4'h8;
      8'h6F:   code = 4'h9;
      8'h00:   code = 4'hA;
      8'h3E:   code = 4'hB;
      8'h79:   code = 4'hC;
      8'h50:   code = 4'hD;
      8'h40:   code = 4'hE;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Sample stage and run tracker state
  logic [7:0]       samp_q;
  logic             samp_vld_q;
  logic [7:0]       prev_q;
  logic             prev_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             slot_phase_q;   // 0: waiting for first accept, 1: repeat slots
  logic             char_valid_q;
  logic [3:0]       char_code_q;

  // Frame FSM state and outputs
  state_t           state_q;
  logic [11:0]      slot_q;         // chars 1..3; char 4 is taken straight from char_code_q
  logic             frame_valid_q;
  logic             frame_is_over_q;
  logic [15:0]      score_q;
  logic             error_q;

  logic             same_d;
  logic [CNT_W-1:0] run_d;
  logic             phase_d;
  logic             accept_d;
  logic [15:0]      frame_d;
  logic             over_d;
  logic             score_ok_d;

  // Run length of the sample being processed and whether it triggers an accept
  always_comb begin
    same_d   = prev_vld_q && (samp_q == prev_q);
    run_d    = CNT_ONE;
    phase_d  = 1'b0;
    if (same_d) begin
      run_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      phase_d = slot_phase_q;
    end
    accept_d = samp_vld_q &&
               ((!phase_d && run_d == STABLE_C) || (phase_d && run_d == SLOT_C));
  end

  // Sample the bus, track runs of equal samples, register accepted characters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q       <= 8'h00;
      samp_vld_q   <= 1'b0;
      prev_q       <= 8'h00;
      prev_vld_q   <= 1'b0;
      cnt_q        <= '0;
      slot_phase_q <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= 4'h0;
    end else begin
      samp_q       <= bus.seg_in;
      samp_vld_q   <= 1'b1;
      char_valid_q <= accept_d;
      if (samp_vld_q) begin
        prev_q     <= samp_q;
        prev_vld_q <= 1'b1;
        if (accept_d) begin
          // restart counting toward the next repeat slot
          cnt_q        <= '0;
          slot_phase_q <= 1'b1;
          char_code_q  <= decode_seg(samp_q);
        end else begin
          cnt_q        <= run_d;
          slot_phase_q <= phase_d;
        end
      end
    end
  end

  // Classify the completed frame as chars 1..3 plus the char being accepted
  always_comb begin
    frame_d    = {slot_q, char_code_q};
    over_d     = (frame_d == 16'h0BCD);
    score_ok_d = (frame_d[15:12] <= 4'd9) && (frame_d[11:8] <= 4'd9) &&
                 (frame_d[7:4] <= 4'd9)   && (frame_d[3:0] <= 4'd9);
  end

  // Frame FSM: reassemble blank-delimited 4-character frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= HUNT;
      slot_q          <= '0;
      frame_valid_q   <= 1'b0;
      frame_is_over_q <= 1'b0;
      score_q         <= '0;
      error_q         <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      error_q       <= 1'b0;
      if (char_valid_q) begin
        if (state_q == HUNT) begin
          if (char_code_q == CODE_BLANK) begin
            state_q <= C1;
          end else if (char_code_q == CODE_INVALID) begin
            error_q <= 1'b1;
          end
        end else if (char_code_q == CODE_BLANK) begin
          // a blank after C1 means the previous frame was cut short
          if (state_q != C1) begin
            error_q <= 1'b1;
          end
          state_q <= C1;
        end else if (char_code_q == CODE_DASH || char_code_q == CODE_INVALID) begin
          error_q <= 1'b1;
          state_q <= HUNT;
        end else begin
          case (state_q)
            C1: begin
              slot_q[11:8] <= char_code_q;
              state_q      <= C2;
            end
            C2: begin
              slot_q[7:4] <= char_code_q;
              state_q     <= C3;
            end
            C3: begin
              slot_q[3:0] <= char_code_q;
              state_q     <= C4;
            end
            default: begin
              state_q <= HUNT;
              if (over_d) begin
                frame_valid_q   <= 1'b1;
                frame_is_over_q <= 1'b1;
              end else if (score_ok_d) begin
                frame_valid_q   <= 1'b1;
                frame_is_over_q <= 1'b0;
                score_q         <= frame_d;
              end else begin
                error_q <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.char_valid    = char_valid_q;
  assign bus.char_code     = char_code_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_is_over = frame_is_over_q;
  assign bus.score_bcd     = score_q;
  assign bus.error         = error_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_seg_stream_decoder.sv
// Bench for seg_stream_decoder. A behavioural model follows the driven
// segment byte edge by edge, computes run lengths with plain arithmetic and
// turns accepted characters into a list of expected events (char, frame,
// error) stamped with the edge after which each must be visible. A monitor
// records the observed pulses the same way; each scenario task compares both.
module tb_seg_stream_decoder;
  localparam int STABLE = 4;
  localparam int SLOT   = 10;
  localparam int CW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] drv_seg = 8'h00;

  seg_stream_decoder_if bus ();
  assign bus.seg_in = drv_seg;

  seg_stream_decoder #(
    .STABLE_CYCLES(STABLE),
    .SLOT_CYCLES  (SLOT),
    .CNT_W        (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // event word: {type[1:0], edge[29:0], payload[31:0]}; 1=char 2=frame 3=error
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  // reference model state
  logic [7:0] pat_tbl [15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                               8'h07, 8'h7F, 8'h6F, 8'h00, 8'h3E, 8'h79, 8'h50, 8'h40};
  bit         m_have;
  logic [7:0] m_pat;
  int         m_run;
  bit         m_in_frame;
  int         m_slots[$];
  logic [15:0] m_score;
  bit         m_over;
  logic [3:0] m_code;

  function automatic logic [3:0] ref_decode(input logic [7:0] p);
    for (int i = 0; i < 15; i++) if (pat_tbl[i] == p) return 4'(i);
    return 4'hF;
  endfunction

  function automatic void model_reset();
    m_have = 0; m_pat = 8'h00; m_run = 0; m_in_frame = 0; m_slots.delete();
    m_score = 16'h0; m_over = 0; m_code = 4'h0;
    exp_q.delete(); obs_q.delete();
  endfunction

  function automatic void push_err(input int ev);
    exp_q.push_back({2'd3, 30'(ev), 32'd0});
  endfunction

  function automatic void model_char(input logic [3:0] c, input int ev);
    bit all_digits;
    exp_q.push_back({2'd1, 30'(ev), 28'd0, c});
    m_code = c;
    if (!m_in_frame) begin
      if (c == 4'hA) begin m_in_frame = 1; m_slots.delete(); end
      else if (c == 4'hF) push_err(ev + 1);
    end else if (c == 4'hA) begin
      if (m_slots.size() != 0) push_err(ev + 1);
      m_slots.delete();
    end else if (c == 4'hE || c == 4'hF) begin
      push_err(ev + 1);
      m_in_frame = 0;
    end else begin
      m_slots.push_back(int'(c));
      if (m_slots.size() == 4) begin
        m_in_frame = 0;
        all_digits = 1;
        foreach (m_slots[i]) if (m_slots[i] > 9) all_digits = 0;
        if (m_slots[0] == 0 && m_slots[1] == 11 && m_slots[2] == 12 && m_slots[3] == 13) begin
          m_over = 1;
          exp_q.push_back({2'd2, 30'(ev + 1), 15'd0, 1'b1, m_score});
        end else if (all_digits) begin
          m_over = 0;
          m_score = {4'(m_slots[0]), 4'(m_slots[1]), 4'(m_slots[2]), 4'(m_slots[3])};
          exp_q.push_back({2'd2, 30'(ev + 1), 15'd0, 1'b0, m_score});
        end else begin
          push_err(ev + 1);
        end
      end
    end
  endfunction

  // Model: one sample per rising edge outside reset
  always @(posedge clk) begin
    edge_n++;
    if (!rst) begin
      if (!m_have || drv_seg != m_pat) begin
        m_pat = drv_seg; m_run = 1; m_have = 1;
      end else if (m_run < 1000000) begin
        m_run++;
      end
      if (m_run == STABLE || (m_run > STABLE && (m_run - STABLE) % SLOT == 0))
        model_char(ref_decode(drv_seg), edge_n + 1);
    end
  end

  // Monitor: record observed pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.char_valid)  obs_q.push_back({2'd1, edge_n[29:0], 28'd0, bus.char_code});
      if (bus.frame_valid) obs_q.push_back({2'd2, edge_n[29:0], 15'd0, bus.frame_is_over, bus.score_bcd});
      if (bus.error)       obs_q.push_back({2'd3, edge_n[29:0], 32'd0});
    end
  end

  function automatic int due_count();
    int n = 0;
    while (n < exp_q.size() && int'(exp_q[n][61:32]) <= edge_n) n++;
    return n;
  endfunction

  function automatic int count_obs(input logic [1:0] typ);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][63:62] == typ) n++;
    return n;
  endfunction

  task automatic drive_seg(input logic [7:0] p, input int n);
    drv_seg = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.char_valid !== 1'b0) begin bad++; $display("FAIL rst_char_valid got=%b want=0", bus.char_valid); end
    total++; if (bus.char_code !== 4'h0) begin bad++; $display("FAIL rst_char_code got=%h want=0", bus.char_code); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_frame_valid got=%b want=0", bus.frame_valid); end
    total++; if (bus.frame_is_over !== 1'b0) begin bad++; $display("FAIL rst_frame_is_over got=%b want=0", bus.frame_is_over); end
    total++; if (bus.score_bcd !== 16'h0) begin bad++; $display("FAIL rst_score got=%h want=0", bus.score_bcd); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", bus.error); end
    total++; if (bus.dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", bus.dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_score_frame();
    int n_due;
    drive_seg(8'h00, 10); drive_seg(8'h06, 10); drive_seg(8'h5B, 10);
    drive_seg(8'h4F, 10); drive_seg(8'h66, 10);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd1) !== 5) begin bad++; $display("FAIL score_char_pulses got=%0d want=5", count_obs(2'd1)); end
    total++; if (count_obs(2'd3) !== 0) begin bad++; $display("FAIL score_errors got=%0d want=0", count_obs(2'd3)); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL score_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL score_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.score_bcd !== 16'h1234) begin bad++; $display("FAIL score_bcd got=%h want=1234", bus.score_bcd); end
    total++; if (bus.frame_is_over !== 1'b0) begin bad++; $display("FAIL score_is_over got=%b want=0", bus.frame_is_over); end
    total++; if (bus.char_code !== 4'h4) begin bad++; $display("FAIL score_last_code got=%h want=4", bus.char_code); end
  endtask

  task automatic test_over_frame();
    int n_due;
    drive_seg(8'h00, 10); drive_seg(8'h3F, 10); drive_seg(8'h3E, 10);
    drive_seg(8'h79, 10); drive_seg(8'h50, 10);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd2) !== 1) begin bad++; $display("FAIL over_frames got=%0d want=1", count_obs(2'd2)); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL over_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL over_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.frame_is_over !== 1'b1) begin bad++; $display("FAIL over_is_over got=%b want=1", bus.frame_is_over); end
    total++; if (bus.score_bcd !== 16'h1234) begin bad++; $display("FAIL over_score_kept got=%h want=1234", bus.score_bcd); end
  endtask

  task automatic test_repeats();
    int n_due;
    drive_seg(8'h00, 10); drive_seg(8'h6F, 40);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd1) !== 5) begin bad++; $display("FAIL rep_char_pulses got=%0d want=5", count_obs(2'd1)); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL rep_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rep_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.score_bcd !== 16'h9999) begin bad++; $display("FAIL rep_score got=%h want=9999", bus.score_bcd); end
    total++; if (bus.frame_is_over !== 1'b0) begin bad++; $display("FAIL rep_is_over got=%b want=0", bus.frame_is_over); end
  endtask

  task automatic test_glitch();
    int n_due;
    drive_seg(8'h00, 10); drive_seg(8'h06, 3); drive_seg(8'h00, 10);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd1) !== 2) begin bad++; $display("FAIL glitch_char_pulses got=%0d want=2", count_obs(2'd1)); end
    total++; if (count_obs(2'd3) !== 0) begin bad++; $display("FAIL glitch_errors got=%0d want=0", count_obs(2'd3)); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL glitch_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL glitch_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.dbg_state !== 3'd1) begin bad++; $display("FAIL glitch_state got=%0d want=1", bus.dbg_state); end
  endtask

  task automatic test_invalid();
    int n_due;
    drive_seg(8'h06, 10); drive_seg(8'h5B, 10); drive_seg(8'h80, 4);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd3) !== 1) begin bad++; $display("FAIL inv_errors got=%0d want=1", count_obs(2'd3)); end
    total++; if (bus.char_code !== 4'hF) begin bad++; $display("FAIL inv_code got=%h want=f", bus.char_code); end
    total++; if (bus.dbg_state !== 3'd0) begin bad++; $display("FAIL inv_state got=%0d want=0", bus.dbg_state); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL inv_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL inv_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    // four digits without a leading blank must not form a frame
    drive_seg(8'h06, 10); drive_seg(8'h5B, 10); drive_seg(8'h4F, 10); drive_seg(8'h66, 10);
    drive_seg(8'h00, 10); drive_seg(8'h07, 10); drive_seg(8'h06, 10); drive_seg(8'h07, 10); drive_seg(8'h06, 10);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (count_obs(2'd2) !== 1) begin bad++; $display("FAIL inv_resync_frames got=%0d want=1", count_obs(2'd2)); end
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL inv2_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL inv2_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.score_bcd !== 16'h7171) begin bad++; $display("FAIL inv_resync_score got=%h want=7171", bus.score_bcd); end
  endtask

  task automatic test_async_reset();
    int n_due;
    drive_seg(8'h00, 10); drive_seg(8'h06, 10); drive_seg(8'h5B, 10);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (bus.score_bcd !== 16'h0) begin bad++; $display("FAIL arst_score got=%h want=0", bus.score_bcd); end
    total++; if (bus.char_code !== 4'h0) begin bad++; $display("FAIL arst_code got=%h want=0", bus.char_code); end
    total++; if (bus.frame_is_over !== 1'b0) begin bad++; $display("FAIL arst_is_over got=%b want=0", bus.frame_is_over); end
    total++; if ({bus.char_valid, bus.frame_valid, bus.error} !== 3'b000) begin bad++; $display("FAIL arst_pulses got=%b want=000", {bus.char_valid, bus.frame_valid, bus.error}); end
    total++; if (bus.dbg_state !== 3'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", bus.dbg_state); end
    model_reset();
    drv_seg = 8'h00;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive_seg(8'h00, 10); drive_seg(8'h7F, 10); drive_seg(8'h07, 10);
    drive_seg(8'h6D, 10); drive_seg(8'h3F, 10);
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL arst_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL arst_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    total++; if (bus.score_bcd !== 16'h8750) begin bad++; $display("FAIL arst_frame_score got=%h want=8750", bus.score_bcd); end
  endtask

  task automatic test_random();
    int n_due;
    int kind;
    for (int s = 0; s < 150; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        // well-formed attempt: blank plus four random table characters
        drive_seg(8'h00, $urandom_range(STABLE, 12));
        for (int c = 0; c < 4; c++) drive_seg(pat_tbl[$urandom_range(0, 9)], $urandom_range(STABLE, 12));
      end else if (kind < 9) begin
        drive_seg(pat_tbl[$urandom_range(0, 14)], $urandom_range(1, 25));
      end else begin
        drive_seg(8'($urandom_range(0, 255)), $urandom_range(1, 25));
      end
    end
    repeat (3) @(negedge clk); #1;
    n_due = due_count();
    total++; if (obs_q.size() !== n_due) begin bad++; $display("FAIL rand_event_count got=%0d want=%0d", obs_q.size(), n_due); end
    for (int i = 0; i < n_due && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    repeat (n_due) void'(exp_q.pop_front());
    obs_q.delete();
    if (exp_q.size() == 0) begin
      total++; if (bus.score_bcd !== m_score) begin bad++; $display("FAIL rand_score got=%h want=%h", bus.score_bcd, m_score); end
      total++; if (bus.char_code !== m_code) begin bad++; $display("FAIL rand_code got=%h want=%h", bus.char_code, m_code); end
      total++; if (bus.frame_is_over !== m_over) begin bad++; $display("FAIL rand_is_over got=%b want=%b", bus.frame_is_over, m_over); end
      total++; if (bus.dbg_state !== 3'(m_in_frame ? 1 + m_slots.size() : 0)) begin
        bad++; $display("FAIL rand_state got=%0d want=%0d", bus.dbg_state, m_in_frame ? 1 + m_slots.size() : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_score_frame();
    test_over_frame();
    test_repeats();
    test_glitch();
    test_invalid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_stream_decoder.md
# seg_stream_decoder

Receive-side decoder for the 7-segment character stream driven by the game block's `uo_out`. It samples the segment byte and accepts a character once the pattern has held stable. It decodes the pattern back to a 4-bit character code and reassembles blank-delimited 4-character frames into either a BCD score or an OVER indication. It sits in loopback/scoreboard position, either on-chip monitoring the display bus or on the host side reading the pins.

## Interface
- `STABLE_CYCLES`, default 8: consecutive equal samples required to accept a newly changed pattern; must be ≥2 and < `SLOT_CYCLES`.
- `SLOT_CYCLES`, default 10000000: further consecutive equal samples after each accept before the same pattern is accepted again (repeated characters).
- `CNT_W`, default 24: run-counter width; must hold `SLOT_CYCLES`.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `seg_in` in 8: segment byte, bit order .GFEDCBA.
- `char_valid` out 1: one-cycle pulse per accepted character.
- `char_code` out 4: code of the last accepted character; held between pulses.
- `frame_valid` out 1: one-cycle pulse on a well-formed 4-character frame.
- `frame_is_over` out 1: qualifies `frame_valid`; 1 = OVER frame, 0 = score frame; held.
- `score_bcd` out 16: last score frame, char1 in [15:12] … char4 in [3:0]; held.
- `error` out 1: one-cycle pulse on an invalid pattern or a malformed frame.

## Operation
- Decode table:
  - Digits: 0x3F→0x0, 0x06→0x1, 0x5B→0x2, 0x4F→0x3, 0x66→0x4, 0x6D→0x5, 0x7D→0x6, 0x07→0x7, 0x7F→0x8, 0x6F→0x9.
  - Letters and symbols: 0x00→0xA (blank), 0x3E→0xB (V), 0x79→0xC (E), 0x50→0xD (R), 0x40→0xE (dash).
  - Any other byte→0xF (invalid).
  - The "O" of OVER is pattern 0x3F, code 0x0.
- Run tracking:
  - A sample differing from the previous sample restarts the run.
  - The first sample after reset always starts a run.
  - Accept when the run reaches `STABLE_CYCLES` equal samples, then again every further `SLOT_CYCLES` equal samples.
  - The counter saturates and never wraps.
- Frame FSM states: HUNT, C1, C2, C3, C4. Slot n captures the nth character after the blank. Transitions on each accept:
  - HUNT: blank→C1; anything else stays in HUNT, no error, except invalid (0xF), which pulses `error`.
  - C1: blank→stay in C1, no error (re-synced blank).
  - C2–C4: blank→C1 and pulse `error` (truncated frame).
  - C1–C4: dash or invalid→HUNT and pulse `error`.
  - C1–C4: other codes are stored in the current slot, then advance (C1→C2→C3→C4).
  - C4 store→HUNT, then classify the frame:
    - Slots 0x0,0xB,0xC,0xD → `frame_valid`, `frame_is_over`=1; `score_bcd` is unchanged.
    - All four slots ≤0x9 → `frame_valid`, `frame_is_over`=0, `score_bcd` loaded.
    - Anything else → `error` only.
- Reset values:
  - All outputs 0: `char_valid`, `char_code`, `frame_valid`, `frame_is_over`, `score_bcd`, `error`.
  - FSM in HUNT, run counter 0, slot registers 0.
- Reset mid-frame discards the partial frame immediately, with no clock needed.

## Timing
- `seg_in` constant at value P, first sampled at edge k: `char_valid` is high in the cycle following edge k+`STABLE_CYCLES`. `char_code` updates at the same edge.
- Repeat accepts of the same P occur after edge k+`STABLE_CYCLES`+m·`SLOT_CYCLES`, for m≥1.
- `frame_valid`, `frame_is_over`, `score_bcd` and frame-related `error` update one edge after the accepting `char_valid` cycle: latency +1.
- A pattern change sampled on the edge that would have accepted wins; no accept occurs.
- At most one `char_valid` per cycle.
- `frame_valid` and `error` are never high in the same cycle.
- All outputs are registered.

## Test plan
Parameters: `STABLE_CYCLES`=4, `SLOT_CYCLES`=10 unless noted.
- Score frame: 0x00, 0x06, 0x5B, 0x4F, 0x66, 10 cycles each → five `char_valid` pulses with codes A,1,2,3,4; one `frame_valid` with `frame_is_over`=0 and `score_bcd`=0x1234; no `error`.
- Repeats: 0x00 for 10 cycles, then 0x6F for 40 cycles → 0x6F accepted at run samples 4, 14, 24, 34; `score_bcd`=0x9999.
- OVER frame after the score test: 0x00, 0x3F, 0x3E, 0x79, 0x50, 10 cycles each → `frame_valid` with `frame_is_over`=1; `score_bcd` still 0x1234.
- Glitch: a 3-cycle 0x06 inside a blank run → no accept for 0x06. The blank is re-accepted 4 samples later and the FSM stays in C1 with no `error`.
- Invalid pattern: 0x80 held 4 cycles after two digits → `error` pulse, `char_code`=0xF, FSM in HUNT. No `frame_valid` until a blank plus 4 valid characters arrive.
- Async reset after 2 digits, asserted between edges → all outputs 0 before the next edge. A following full frame 0x00, 0x7F, 0x07, 0x6D, 0x3F decodes to `score_bcd`=0x8750.
